// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - state encoding, default configuration and sizing helper for freq_meter
package freq_meter_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] GATE  = 2'd2;
  localparam logic [1:0] LATCH = 2'd3;

  // 1 s gate at a 125 MHz reference; 27 bits holds counts up to 134M
  localparam int unsigned GATE_1S_125M  = 125_000_000;
  localparam int unsigned CNT_W_1S_125M = 27;

  // Gate counter width: one spare bit above what the terminal value needs
  function automatic int unsigned gate_cnt_width(input int unsigned gate_cycles);
    return $clog2(gate_cycles) + 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer with rising-edge pulse for an asynchronous input
module sync_edge_det (
  input  logic clk_ref,
  input  logic rst,
  input  logic d_async,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // s1/s2 resolve metastability, s3 holds the previous synchronized level
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_async;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated-window frequency meter; define FREQ_METER_OVF_EN for a saturating count with ovf
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_1S_125M,
  parameter int unsigned CNT_W       = CNT_W_1S_125M
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             busy,
  output logic             ovf
);

  localparam int unsigned   GW        = gate_cnt_width(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  logic             edge_p;
  logic [1:0]       state_q, state_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             freq_valid_q, freq_valid_d;
`ifdef FREQ_METER_OVF_EN
  logic             ovf_reg_q, ovf_reg_d;
  logic             ovf_q, ovf_d;
`endif

  sync_edge_det u_sync (
    .clk_ref (clk_ref),
    .rst     (rst),
    .d_async (sig_in),
    .rise    (edge_p)
  );

  // Next-state logic: window sequencing, counting and result capture.
  // Results are loaded on the way into LATCH so they are visible during LATCH.
  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    freq_d       = freq_q;
    freq_valid_d = 1'b0;
`ifdef FREQ_METER_OVF_EN
    ovf_reg_d    = ovf_reg_q;
    ovf_d        = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (en) state_d = ARM;
      end
      ARM: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
`ifdef FREQ_METER_OVF_EN
        ovf_reg_d  = 1'b0;
`endif
        state_d    = en ? GATE : IDLE;
      end
      GATE: begin
        if (!en) begin
          // Abort: results from the previous window stay in place
          state_d = IDLE;
        end else begin
          if (edge_p) begin
`ifdef FREQ_METER_OVF_EN
            if (&edge_cnt_q) ovf_reg_d = 1'b1;
            else             edge_cnt_d = edge_cnt_q + CNT_W'(1);
`else
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
`endif
          end
          if (gate_cnt_q == GATE_LAST) begin
            state_d      = LATCH;
            freq_d       = edge_cnt_d;
            freq_valid_d = 1'b1;
`ifdef FREQ_METER_OVF_EN
            ovf_d        = ovf_reg_d;
`endif
          end else begin
            gate_cnt_d = gate_cnt_q + GW'(1);
          end
        end
      end
      LATCH: begin
        state_d = en ? ARM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and output registers; reset clears outputs immediately
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
`ifdef FREQ_METER_OVF_EN
      ovf_reg_q    <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
`ifdef FREQ_METER_OVF_EN
      ovf_reg_q    <= ovf_reg_d;
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign freq       = freq_q;
  assign freq_valid = freq_valid_q;
  assign busy       = (state_q != IDLE);
`ifdef FREQ_METER_OVF_EN
  assign ovf        = ovf_q;
`else
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - self-checking bench for freq_meter against a window edge-count model
module tb_freq_meter;

  localparam int G = 100;
  localparam int P = G + 2;
`ifdef FREQ_METER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       sig_in;
  logic [7:0] freq8;
  logic       valid8, busy8, ovf8;
  logic [3:0] freq4;
  logic       valid4, busy4, ovf4;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int rises[$];
  int sig_mode = 0;
  int half_p   = 5;
  int run      = 1;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (
    .clk_ref(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(freq8), .freq_valid(valid8), .busy(busy8), .ovf(ovf8)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
    .clk_ref(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(freq4), .freq_valid(valid4), .busy(busy4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // sig_in source: 0 low, 1 high, 2 fixed half period, 3 random half periods of 2..7
  initial begin
    logic nv;
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      nv = sig_in;
      case (sig_mode)
        0: nv = 1'b0;
        1: nv = 1'b1;
        default: begin
          run = run - 1;
          if (run <= 0) begin
            nv  = ~sig_in;
            run = (sig_mode == 2) ? half_p : int'($urandom_range(2, 7));
          end
        end
      endcase
      if (nv && !sig_in) rises.push_back(cyc);
      sig_in = nv;
    end
  end

  // Rising edges of sig_in driven in cycles [c0, c0+G-1] fall inside the window opened at c0
  function automatic int count_rises(input int c0);
    int n = 0;
    foreach (rises[i]) if (rises[i] >= c0 && rises[i] <= c0 + G - 1) n++;
    return n;
  endfunction

  function automatic int exp_freq(input int n, input int w);
    int top = (1 << w) - 1;
    if (OVF_ON) return (n > top) ? top : n;
    return n % (1 << w);
  endfunction

  function automatic int exp_ovf(input int n, input int w);
    return (OVF_ON && n > (1 << w) - 1) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise en in the current (IDLE) cycle, run nwin back-to-back windows, then drop en
  task automatic measure(input int nwin, input int fixed_exp);
    int c0, n;
    bit early;
    en = 1'b1;
    c0 = cyc;
    for (int w = 0; w < nwin; w++) begin
      early = 1'b0;
      for (int k = 1; k < P; k++) begin
        tick();
        if (valid8 || valid4) early = 1'b1;
        if (w == 0 && k == 1) check("busy_rise", busy8, 1);
      end
      tick();
      n = count_rises(c0 + w * P);
      check("early_valid", early, 0);
      check("valid8", valid8, 1);
      check("valid4", valid4, 1);
      check("freq8", freq8, exp_freq(n, 8));
      check("ovf8", ovf8, exp_ovf(n, 8));
      check("freq4", freq4, exp_freq(n, 4));
      check("ovf4", ovf4, exp_ovf(n, 4));
      if (fixed_exp >= 0) check("freq_nominal", freq8, fixed_exp);
      if (w == nwin - 1) en = 1'b0;
    end
    tick();
    check("busy_fall", busy8, 0);
    check("valid_pulse", valid8, 0);
  endtask

  task automatic abort_test();
    bit seen;
    en = 1'b1;
    for (int k = 1; k <= 51; k++) tick();
    check("abort_busy_mid", busy8, 1);
    en = 1'b0;
    tick();
    check("abort_busy", busy8, 0);
    check("abort_valid", valid8, 0);
    check("abort_freq_hold", freq8, 10);
    seen = 1'b0;
    for (int k = 0; k < P + 10; k++) begin
      tick();
      if (valid8 || valid4) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);
    check("abort_freq_hold2", freq8, 10);
  endtask

  task automatic reset_test();
    int c1, n;
    bit early;
    en = 1'b1;
    for (int k = 0; k < 60; k++) tick();
    check("rst_pre_busy", busy8, 1);
    sig_mode = 0;
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_freq", freq8, 0);
    check("rst_async_busy", busy8, 0);
    check("rst_async_valid", valid8, 0);
    check("rst_async_ovf4", ovf4, 0);
    repeat (3) tick();
    #3;
    rst = 1'b0;
    sig_mode = 2;
    half_p = 5;
    c1 = cyc;
    early = 1'b0;
    for (int k = 1; k < P; k++) begin
      tick();
      if (valid8) early = 1'b1;
    end
    tick();
    n = count_rises(c1);
    check("rst_early_valid", early, 0);
    check("rst_valid", valid8, 1);
    check("rst_freq8", freq8, exp_freq(n, 8));
    check("rst_freq_nominal", freq8, 10);
    en = 1'b0;
    tick();
    check("rst_busy_fall", busy8, 0);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    tick();
    check("reset_freq", freq8, 0);
    check("reset_valid", valid8, 0);
    check("reset_busy", busy8, 0);
    check("reset_ovf", ovf8, 0);
    check("reset_freq4", freq4, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // period 10: single window, then continuous mode
    sig_mode = 2;
    half_p   = 5;
    repeat (12) tick();
    measure(1, 10);
    measure(3, 10);

    // period 4: 25 edges per window, overflows the 4-bit instance
    half_p = 2;
    repeat (8) tick();
    measure(2, 25);
    check("ovf_w4_freq", freq4, OVF_ON ? 15 : 9);
    check("ovf_w4_flag", ovf4, OVF_ON ? 1 : 0);

    // static input
    sig_mode = 1;
    repeat (5) tick();
    measure(1, 0);
    sig_mode = 0;
    repeat (5) tick();
    measure(1, 0);

    // abort after a window of 10
    sig_mode = 2;
    half_p   = 5;
    repeat (12) tick();
    measure(1, 10);
    abort_test();

    // random input, random gaps and window counts
    sig_mode = 3;
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 20)) tick();
      measure(int'($urandom_range(1, 3)), -1);
    end

    // asynchronous reset in the middle of a window
    sig_mode = 2;
    half_p   = 5;
    repeat (12) tick();
    measure(1, 10);
    reset_test();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
